// File: rtl/output_port_allocator.sv
// Wormhole output-port allocator: round-robin header arbitration, then the port
// stays locked to the winning input until its packet has been transferred.
module output_port_allocator #(
   parameter int N_REQ  = 3,
   parameter int LEN_W  = 12,
   parameter int TYPE_W = 3
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_REQ-1:0]          req,
   input  logic [N_REQ*TYPE_W-1:0]   flit_type,
   input  logic [N_REQ*LEN_W-1:0]    length,
   input  logic                      dcts,
   output logic [N_REQ-1:0]          grant,
   output logic [N_REQ-1:0]          sel,
   output logic                      busy,
   output logic                      len_err
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int N_PAD = 1 << IDX_W;
   localparam logic [TYPE_W-1:0] HEADER = TYPE_W'(1);
   localparam logic [TYPE_W-1:0] TAIL   = TYPE_W'(4);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HEAD = 2'd1,
      BODY = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [IDX_W-1:0]   owner_q, owner_d;
   logic [LEN_W-1:0]   cnt_q, cnt_d;
   logic               len_err_q, len_err_d;

   logic [N_REQ-1:0]   cand;
   logic [TYPE_W-1:0]  ftype [N_PAD];
   logic [LEN_W-1:0]   flen  [N_PAD];
   logic [N_REQ-1:0]   own_oh;
   logic [IDX_W-1:0]   winner;
   logic [IDX_W-1:0]   nxt_ptr;
   logic               found;
   logic               go;
   logic               last_cnt;
   logic               is_tail;

   // Arrays padded to a power of two so owner/winner indexing stays in range
   for (genvar i = 0; i < N_PAD; i++) begin : g_unpack
      if (i < N_REQ) begin : g_real
         assign ftype[i] = flit_type[i*TYPE_W +: TYPE_W];
         assign flen[i]  = length[i*LEN_W +: LEN_W];
         assign cand[i]  = req[i] && (flit_type[i*TYPE_W +: TYPE_W] == HEADER);
      end else begin : g_pad
         assign ftype[i] = '0;
         assign flen[i]  = '0;
      end
   end

   always_comb begin
      int idx;
      found  = 1'b0;
      winner = '0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = (int'(ptr_q) + k) % N_REQ;
         if (!found && cand[idx]) begin
            found  = 1'b1;
            winner = IDX_W'(idx);
         end
      end
   end

   assign own_oh  = N_REQ'(1) << owner_q;
   assign nxt_ptr = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
   assign go      = (state_q != IDLE) && |(own_oh & req) && dcts;
   assign last_cnt = (cnt_q == LEN_W'(1));
   assign is_tail  = (ftype[owner_q] == TAIL);

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      owner_d   = owner_q;
      cnt_d     = cnt_q;
      len_err_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (found) begin
               owner_d = winner;
               cnt_d   = flen[winner];
               state_d = HEAD;
            end
         end
         HEAD: begin
            if (go) begin
               if (cnt_q == '0) begin
                  state_d = IDLE;
                  ptr_d   = nxt_ptr;
               end else begin
                  state_d = BODY;
               end
            end
         end
         BODY: begin
            if (go) begin
               cnt_d     = cnt_q - LEN_W'(1);
               len_err_d = last_cnt ^ is_tail;
               // Whichever end marker arrives first closes the packet
               if (last_cnt || is_tail) begin
                  state_d = IDLE;
                  ptr_d   = nxt_ptr;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         owner_q   <= '0;
         cnt_q     <= '0;
         len_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         owner_q   <= owner_d;
         cnt_q     <= cnt_d;
         len_err_q <= len_err_d;
      end
   end

   assign busy    = (state_q != IDLE);
   assign sel     = busy ? own_oh : '0;
   assign grant   = go ? own_oh : '0;
   assign len_err = len_err_q;

endmodule

// File: tb/tb_output_port_allocator.sv
// Directed bench for output_port_allocator: per-cycle vector table plus a
// maximum-length packet sequence.
module tb_output_port_allocator;

   localparam logic [2:0] H = 3'b001;
   localparam logic [2:0] B = 3'b010;
   localparam logic [2:0] T = 3'b100;
   localparam logic [2:0] N = 3'b000;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  req;
   logic [8:0]  flit_type;
   logic [35:0] length;
   logic        dcts;
   logic [2:0]  grant;
   logic [2:0]  sel;
   logic        busy;
   logic        len_err;

   int n_chk  = 0;
   int n_fail = 0;

   output_port_allocator dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .flit_type (flit_type),
      .length    (length),
      .dcts      (dcts),
      .grant     (grant),
      .sel       (sel),
      .busy      (busy),
      .len_err   (len_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [2:0]  req;
      logic [8:0]  ft;
      logic [35:0] len;
      logic        dcts;
      logic [2:0]  eg;
      logic [2:0]  es;
      logic        eb;
      logic        ee;
   } vec_t;

   vec_t tbl[$];

   task automatic v(input logic r, input logic [2:0] rq,
                    input logic [2:0] t2, input logic [2:0] t1,
                    input logic [2:0] t0, input logic [11:0] l2,
                    input logic [11:0] l1, input logic [11:0] l0,
                    input logic d, input logic [2:0] eg,
                    input logic [2:0] es, input logic eb,
                    input logic ee);
      vec_t e;
      e.rst = r;  e.req = rq;  e.ft = {t2, t1, t0};
      e.len = {l2, l1, l0};  e.dcts = d;
      e.eg = eg;  e.es = es;  e.eb = eb;  e.ee = ee;
      tbl.push_back(e);
   endtask

   task automatic chk(input string name, input int idx,
                      input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s vec %0d: got %0h expected %0h",
                  name, idx, act, exp);
      end
   endtask

   initial begin
      int g;
      bit done;
      bit lerr;

      // reset: two cycles with contending headers
      v(0, 3'b111, H, H, H, 0, 0, 0, 1, 3'b000, 3'b000, 0, 0);
      v(0, 3'b111, H, H, H, 0, 0, 0, 1, 3'b000, 3'b000, 0, 0);
      // single request on input 1, length 2
      v(1, 3'b010, N, H, N, 0, 2, 0, 1, 3'b000, 3'b000, 0, 0);
      v(1, 3'b010, N, H, N, 0, 2, 0, 1, 3'b010, 3'b010, 1, 0);
      v(1, 3'b010, N, B, N, 0, 0, 0, 1, 3'b010, 3'b010, 1, 0);
      v(1, 3'b010, N, T, N, 0, 0, 0, 1, 3'b010, 3'b010, 1, 0);
      // ptr now 2: input 2 beats input 0
      v(1, 3'b101, H, N, H, 0, 0, 0, 1, 3'b000, 3'b000, 0, 0);
      v(1, 3'b101, H, N, H, 0, 0, 0, 1, 3'b100, 3'b100, 1, 0);
      // three-way contention from ptr 0, header-only packets
      v(1, 3'b111, H, H, H, 0, 0, 0, 1, 3'b000, 3'b000, 0, 0);
      v(1, 3'b111, H, H, H, 0, 0, 0, 1, 3'b001, 3'b001, 1, 0);
      v(1, 3'b110, H, H, N, 0, 0, 0, 1, 3'b000, 3'b000, 0, 0);
      v(1, 3'b110, H, H, N, 0, 0, 0, 1, 3'b010, 3'b010, 1, 0);
      v(1, 3'b100, H, N, N, 0, 0, 0, 1, 3'b000, 3'b000, 0, 0);
      v(1, 3'b100, H, N, N, 0, 0, 0, 1, 3'b100, 3'b100, 1, 0);
      // stall mid-body, owner 0, length 3
      v(1, 3'b001, N, N, H, 0, 0, 3, 1, 3'b000, 3'b000, 0, 0);
      v(1, 3'b001, N, N, H, 0, 0, 3, 1, 3'b001, 3'b001, 1, 0);
      v(1, 3'b001, N, N, B, 0, 0, 0, 1, 3'b001, 3'b001, 1, 0);
      v(1, 3'b001, N, N, B, 0, 0, 0, 0, 3'b000, 3'b001, 1, 0);
      v(1, 3'b001, N, N, B, 0, 0, 0, 0, 3'b000, 3'b001, 1, 0);
      v(1, 3'b001, N, N, B, 0, 0, 0, 0, 3'b000, 3'b001, 1, 0);
      v(1, 3'b001, N, N, B, 0, 0, 0, 0, 3'b000, 3'b001, 1, 0);
      v(1, 3'b001, N, N, B, 0, 0, 0, 1, 3'b001, 3'b001, 1, 0);
      v(1, 3'b001, N, N, T, 0, 0, 0, 1, 3'b001, 3'b001, 1, 0);
      // early TAIL (len 5), body flit on input 1 ignored, req gap
      v(1, 3'b011, N, B, H, 0, 0, 5, 1, 3'b000, 3'b000, 0, 0);
      v(1, 3'b011, N, B, H, 0, 0, 5, 1, 3'b001, 3'b001, 1, 0);
      v(1, 3'b000, N, N, B, 0, 0, 0, 1, 3'b000, 3'b001, 1, 0);
      v(1, 3'b001, N, N, B, 0, 0, 0, 1, 3'b001, 3'b001, 1, 0);
      v(1, 3'b001, N, N, T, 0, 0, 0, 1, 3'b001, 3'b001, 1, 0);
      v(1, 3'b000, N, N, N, 0, 0, 0, 1, 3'b000, 3'b000, 0, 1);
      v(1, 3'b000, N, N, N, 0, 0, 0, 1, 3'b000, 3'b000, 0, 0);
      // count expires without TAIL
      v(1, 3'b001, N, N, H, 0, 0, 1, 1, 3'b000, 3'b000, 0, 0);
      v(1, 3'b001, N, N, H, 0, 0, 1, 1, 3'b001, 3'b001, 1, 0);
      v(1, 3'b001, N, N, B, 0, 0, 0, 1, 3'b001, 3'b001, 1, 0);
      v(1, 3'b000, N, N, N, 0, 0, 0, 1, 3'b000, 3'b000, 0, 1);
      // reset during body of owner 2, then 0 must win over 2
      v(1, 3'b100, H, N, N, 4, 0, 0, 1, 3'b000, 3'b000, 0, 0);
      v(1, 3'b100, H, N, N, 4, 0, 0, 1, 3'b100, 3'b100, 1, 0);
      v(1, 3'b100, B, N, N, 0, 0, 0, 1, 3'b100, 3'b100, 1, 0);
      v(0, 3'b100, B, N, N, 0, 0, 0, 1, 3'b100, 3'b100, 1, 0);
      v(1, 3'b101, H, N, H, 0, 0, 0, 1, 3'b000, 3'b000, 0, 0);
      v(1, 3'b101, H, N, H, 0, 0, 0, 1, 3'b001, 3'b001, 1, 0);

      rst = 1'b0;  req = 3'b111;  flit_type = {H, H, H};
      length = '0;  dcts = 1'b1;
      @(posedge clk);

      for (int i = 0; i < tbl.size(); i++) begin
         #1;
         rst = tbl[i].rst;  req = tbl[i].req;
         flit_type = tbl[i].ft;  length = tbl[i].len;
         dcts = tbl[i].dcts;
         @(negedge clk);
         chk("grant",   i, 32'(grant),   32'(tbl[i].eg));
         chk("sel",     i, 32'(sel),     32'(tbl[i].es));
         chk("busy",    i, 32'(busy),    32'(tbl[i].eb));
         chk("len_err", i, 32'(len_err), 32'(tbl[i].ee));
         @(posedge clk);
      end

      // longest packet: length 4095 -> 4096 flits on input 1
      #1;
      rst = 1'b1;  req = 3'b010;  dcts = 1'b1;
      length = {12'd0, 12'd4095, 12'd0};
      g = 0;  done = 1'b0;  lerr = 1'b0;
      for (int k = 0; k < 5000 && !done; k++) begin
         flit_type = {N, (g == 0) ? H : (g == 4095) ? T : B, N};
         @(negedge clk);
         if (grant == 3'b010) g++;
         if (len_err) lerr = 1'b1;
         if (g > 0 && !busy) done = 1'b1;
         @(posedge clk);
         #1;
      end
      chk("maxlen_grants", 0, 32'(g), 32'd4096);
      chk("maxlen_release", 0, 32'(done), 32'd1);
      chk("maxlen_len_err", 0, 32'(lerr), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
